move_legality_checker: RTL and testbench

- Sits directly downstream of the position datapath. It takes the candidate tile it computes (changedX/changedY) and decides whether the move is legal by reading the maze tile memory.
- Returns a doneLegal/isLegal handshake to the datapath.
- Also produces the game-state flags the datapath consumes: gameWon, gameOver, scorePlusFive, scoreMinusFive.
- Tile memory is a synchronous ROM with 1-cycle read latency, addressed by y*GRID_W + x.

---
 rtl/move_legality_checker.sv | 154 +++++++++++++++
 tb/tb_move_legality_checker.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/move_legality_checker.sv
// Move legality checker: reads the target maze tile and returns a legal/illegal
// verdict plus the sticky win/lose and per-move score flags.
module move_legality_checker #(
    parameter int GRID_W = 20,
    parameter int GRID_H = 15,
    parameter int ADDR_W = 9,
    parameter int TILE_W = 3
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              clear_game,
    input  logic              check_req,
    input  logic [4:0]        changedX,
    input  logic [4:0]        changedY,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [TILE_W-1:0] mem_rdata,
    output logic              busy,
    output logic              doneLegal,
    output logic              isLegal,
    output logic              gameWon,
    output logic              gameOver,
    output logic              scorePlusFive,
    output logic              scoreMinusFive
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_WAIT,
        S_EVAL,
        S_DONE
    } state_t;

    localparam logic [4:0] GW = 5'(GRID_W);
    localparam logic [4:0] GH = 5'(GRID_H);

    localparam logic [TILE_W-1:0] T_PATH    = TILE_W'(0);
    localparam logic [TILE_W-1:0] T_GOAL    = TILE_W'(2);
    localparam logic [TILE_W-1:0] T_TRAP    = TILE_W'(3);
    localparam logic [TILE_W-1:0] T_BONUS   = TILE_W'(4);
    localparam logic [TILE_W-1:0] T_PENALTY = TILE_W'(5);

    state_t            state_q, state_d;
    logic [4:0]        x_q, x_d;
    logic [4:0]        y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              legal_q, legal_d;
    logic              won_q, won_d;
    logic              over_q, over_d;
    logic              plus_q, plus_d;
    logic              minus_q, minus_d;
    logic [ADDR_W-1:0] lin_addr;
    logic              fast_path;

    // Modular arithmetic, so truncating each operand gives the truncated sum.
    assign lin_addr = ADDR_W'(y_q) * ADDR_W'(GRID_W) + ADDR_W'(x_q);

    assign fast_path = won_q | over_q | (x_q >= GW) | (y_q >= GH);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        legal_d = legal_q;
        won_d   = won_q;
        over_d  = over_q;
        plus_d  = plus_q;
        minus_d = minus_q;

        case (state_q)
            S_IDLE: begin
                if (check_req) begin
                    x_d     = changedX;
                    y_d     = changedY;
                    legal_d = 1'b0;
                    plus_d  = 1'b0;
                    minus_d = 1'b0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (fast_path) begin
                    legal_d = 1'b0;
                    state_d = S_DONE;
                end else begin
                    addr_d  = lin_addr;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: state_d = S_EVAL;
            S_EVAL: begin
                state_d = S_DONE;
                legal_d = 1'b1;
                case (mem_rdata)
                    T_PATH:    ;
                    T_GOAL:    won_d   = 1'b1;
                    T_TRAP:    over_d  = 1'b1;
                    T_BONUS:   plus_d  = 1'b1;
                    T_PENALTY: minus_d = 1'b1;
                    default:   legal_d = 1'b0;
                endcase
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (clear_game) begin
            state_d = S_IDLE;
            x_d     = '0;
            y_d     = '0;
            addr_d  = '0;
            legal_d = 1'b0;
            won_d   = 1'b0;
            over_d  = 1'b0;
            plus_d  = 1'b0;
            minus_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            legal_q <= 1'b0;
            won_q   <= 1'b0;
            over_q  <= 1'b0;
            plus_q  <= 1'b0;
            minus_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            legal_q <= legal_d;
            won_q   <= won_d;
            over_q  <= over_d;
            plus_q  <= plus_d;
            minus_q <= minus_d;
        end
    end

    assign mem_addr       = addr_q;
    assign busy           = (state_q != S_IDLE);
    assign doneLegal      = (state_q == S_DONE);
    assign isLegal        = legal_q;
    assign gameWon        = won_q;
    assign gameOver       = over_q;
    assign scorePlusFive  = plus_q;
    assign scoreMinusFive = minus_q;

endmodule

// File: tb/tb_move_legality_checker.sv
// Bench for move_legality_checker: directed scenarios then random moves,
// checked against a tile-rule reference model and a synchronous ROM.
module tb_move_legality_checker;

    logic       clock;
    logic       resetn;
    logic       clear_game;
    logic       check_req;
    logic [4:0] changedX;
    logic [4:0] changedY;
    logic [8:0] mem_addr;
    logic [2:0] mem_rdata;
    logic       busy;
    logic       doneLegal;
    logic       isLegal;
    logic       gameWon;
    logic       gameOver;
    logic       scorePlusFive;
    logic       scoreMinusFive;

    logic [2:0] rom [0:511];

    int errors = 0;
    int checks = 0;

    // Reference model state
    int   m_addr;
    logic m_legal, m_won, m_over, m_plus, m_minus;

    move_legality_checker #(
        .GRID_W(20), .GRID_H(15), .ADDR_W(9), .TILE_W(3)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .clear_game    (clear_game),
        .check_req     (check_req),
        .changedX      (changedX),
        .changedY      (changedY),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .busy          (busy),
        .doneLegal     (doneLegal),
        .isLegal       (isLegal),
        .gameWon       (gameWon),
        .gameOver      (gameOver),
        .scorePlusFive (scorePlusFive),
        .scoreMinusFive(scoreMinusFive)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) mem_rdata <= rom[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        m_addr  = 0;
        m_legal = 1'b0;
        m_won   = 1'b0;
        m_over  = 1'b0;
        m_plus  = 1'b0;
        m_minus = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".done"}, 32'(doneLegal), 0);
        chk({tag, ".legal"}, 32'(isLegal), 0);
        chk({tag, ".addr"}, 32'(mem_addr), 0);
        chk({tag, ".won"}, 32'(gameWon), 0);
        chk({tag, ".over"}, 32'(gameOver), 0);
        chk({tag, ".plus"}, 32'(scorePlusFive), 0);
        chk({tag, ".minus"}, 32'(scoreMinusFive), 0);
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".legal"}, 32'(isLegal), 32'(m_legal));
        chk({tag, ".won"}, 32'(gameWon), 32'(m_won));
        chk({tag, ".over"}, 32'(gameOver), 32'(m_over));
        chk({tag, ".plus"}, 32'(scorePlusFive), 32'(m_plus));
        chk({tag, ".minus"}, 32'(scoreMinusFive), 32'(m_minus));
        chk({tag, ".addr"}, 32'(mem_addr), 32'(m_addr));
    endtask

    // code < 0 keeps the current ROM contents at the target tile.
    task automatic run_check(input string tag, input int x, input int y,
                             input int code, input bit spam);
        bit   fast;
        int   exp_edge;
        int   got_edge;
        int   extra;
        int   t;
        fast = m_won || m_over || x >= 20 || y >= 15;
        m_plus  = 1'b0;
        m_minus = 1'b0;
        if (fast) begin
            m_legal  = 1'b0;
            exp_edge = 1;
        end else begin
            m_addr = y * 20 + x;
            if (code >= 0) rom[m_addr] = 3'(code);
            t = int'(rom[m_addr]);
            m_legal = (t <= 5 && t != 1);
            if (t == 2) m_won = 1'b1;
            if (t == 3) m_over = 1'b1;
            if (t == 4) m_plus = 1'b1;
            if (t == 5) m_minus = 1'b1;
            exp_edge = 3;
        end

        changedX  = 5'(x);
        changedY  = 5'(y);
        check_req = 1'b1;
        step();
        check_req = 1'b0;
        chk({tag, ".busy0"}, 32'(busy), 1);
        chk({tag, ".legal0"}, 32'(isLegal), 0);

        got_edge = -1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 1) chk({tag, ".addr1"}, 32'(mem_addr), 32'(m_addr));
            if (doneLegal) begin
                got_edge = k;
                break;
            end
            if (spam) begin
                check_req = 1'($urandom_range(0, 1));
                changedX  = 5'($urandom_range(0, 31));
                changedY  = 5'($urandom_range(0, 31));
            end
        end
        chk({tag, ".latency"}, 32'(got_edge), 32'(exp_edge));
        chk_state({tag, ".done"});

        // A request coinciding with doneLegal must be dropped.
        check_req = spam;
        step();
        check_req = 1'b0;
        chk({tag, ".after_done"}, 32'(doneLegal), 0);
        chk({tag, ".after_busy"}, 32'(busy), 0);
        chk_state({tag, ".held"});
        if (spam) begin
            extra = 0;
            for (int k = 0; k < 6; k++) begin
                step();
                if (doneLegal || busy) extra++;
            end
            chk({tag, ".no_extra"}, 32'(extra), 0);
        end
    endtask

    task automatic pulse_clear(input string tag);
        clear_game = 1'b1;
        step();
        clear_game = 1'b0;
        model_reset();
        chk_all_zero(tag);
    endtask

    initial begin
        int rx, ry;
        for (int i = 0; i < 512; i++) rom[i] = 3'($urandom_range(0, 7));
        resetn     = 1'b0;
        clear_game = 1'b0;
        check_req  = 1'b0;
        changedX   = '0;
        changedY   = '0;
        model_reset();
        #1;
        chk_all_zero("reset");
        step();
        step();
        resetn = 1'b1;
        step();

        run_check("path", 3, 2, 0, 0);
        run_check("wall", 5, 5, 1, 0);
        run_check("code7", 5, 5, 7, 0);
        run_check("x_wrap", 31, 0, -1, 0);
        run_check("y_oob", 0, 15, -1, 0);
        run_check("edge_ok", 19, 14, 0, 0);
        run_check("goal", 4, 4, 2, 0);
        run_check("after_won", 1, 1, 0, 0);
        pulse_clear("clear");
        run_check("bonus", 6, 7, 4, 1);
        run_check("bonus_clr", 6, 8, 0, 0);
        run_check("penalty", 2, 9, 5, 1);
        run_check("penalty_clr", 2, 10, 0, 0);
        run_check("trap", 8, 3, 3, 0);
        run_check("after_trap", 8, 4, 0, 0);
        pulse_clear("clear2");

        // Reset partway through a check: outputs drop at once, no pulse follows.
        rom[9 * 20 + 9] = 3'd4;
        changedX  = 5'd9;
        changedY  = 5'd9;
        check_req = 1'b1;
        step();
        check_req = 1'b0;
        step();
        step();
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        chk_all_zero("async_rst");
        begin
            int pulses = 0;
            for (int k = 0; k < 4; k++) begin
                step();
                if (doneLegal) pulses++;
            end
            chk("async_rst.nopulse", 32'(pulses), 0);
        end
        resetn = 1'b1;
        step();

        for (int n = 0; n < 60; n++) begin
            if ((m_won || m_over) && $urandom_range(0, 2) == 0)
                pulse_clear("rnd_clear");
            rx = $urandom_range(0, 23);
            ry = $urandom_range(0, 17);
            run_check("rnd", rx, ry, -1, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
